// File: rtl/pwm_carrier_event_gen.sv
// pwm_carrier_event_gen: triangular PWM carrier with peak/valley pulses and a selectable event qualifier.
// Period and prescale are shadowed and reloaded only at a valley or while idle.
module pwm_carrier_event_gen #(
    parameter int CW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] carrier_max,
    input  logic [DW-1:0] carrier_divider,
    input  logic [1:0]    event_sel,
    output logic [CW-1:0] carrier,
    output logic          carrier_dir,
    output logic          carrier_peak,
    output logic          carrier_valley,
    output logic          event_qualifier,
    output logic [CW-1:0] max_active
);
    logic [DW-1:0] prescaler, div_active;
    logic          idle, tick, at_peak, at_valley;

    assign idle      = !enable || max_active == '0;
    assign tick      = prescaler == div_active;
    // max_active is nonzero whenever these are used, so the subtraction cannot wrap
    assign at_peak   = carrier >= max_active - CW'(1);
    assign at_valley = carrier <= CW'(1);

    assign event_qualifier = (event_sel[0] & carrier_valley) | (event_sel[1] & carrier_peak);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier        <= '0;
            carrier_dir    <= 1'b1;
            carrier_peak   <= 1'b0;
            carrier_valley <= 1'b0;
            prescaler      <= '0;
            max_active     <= '0;
            div_active     <= '0;
        end else begin
            carrier_peak   <= 1'b0;
            carrier_valley <= 1'b0;
            if (idle) begin
                carrier     <= '0;
                carrier_dir <= 1'b1;
                prescaler   <= '0;
                max_active  <= carrier_max;
                div_active  <= carrier_divider;
            end else begin
                prescaler <= tick ? '0 : prescaler + DW'(1);
                if (tick && carrier_dir) begin
                    carrier      <= at_peak ? max_active : carrier + CW'(1);
                    carrier_dir  <= !at_peak;
                    carrier_peak <= at_peak;
                end else if (tick) begin
                    carrier        <= at_valley ? '0 : carrier - CW'(1);
                    carrier_dir    <= at_valley;
                    carrier_valley <= at_valley;
                    if (at_valley) begin
                        max_active <= carrier_max;
                        div_active <= carrier_divider;
                    end
                end
            end
        end
    end
endmodule
